apb_ram_param: RTL and testbench

Parametrised APB4 slave memory: single-port word-organised RAM on the peripheral bus with configurable data width, depth and a fixed number of wait states. Adds byte-lane write strobes (`pstrb`), `pslverr` signalling for out-of-range addresses, and address/control capture in the setup phase. Sits behind the APB decoder as a general-purpose scratch/config store and replaces the fixed 32x256 zero-wait RAM.

---
 rtl/apb_ram_param.sv | 125 ++++++++++++
 tb/tb_apb_ram_param.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_ram_param.sv
// APB4 slave RAM: word-organised single-port memory with byte strobes,
// fixed wait states and an error response for out-of-range word indices.
module apb_ram_param #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_W - OFF_W;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]       WS        = 4'(WAIT_STATES);
    localparam logic [IDX_W:0]   DEPTH_EXT = (IDX_W + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          wcnt;
    logic [3:0]          wcnt_nxt;
    logic                capture;
    logic                done;
    logic                err;
    logic                commit;

    logic [IDX_W-1:0]    cap_idx;
    logic                cap_write;
    logic [DATA_W-1:0]   cap_wdata;
    logic [STRB_W-1:0]   cap_strb;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [MEM_AW-1:0]   mem_addr;

    // Byte-offset bits of paddr are intentionally dropped
    logic                unused_paddr;
    assign unused_paddr = ^paddr;

    // State and wait counter
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Next-state, setup capture strobe and completion
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        capture   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_nxt = ACCESS;
                    wcnt_nxt  = 4'd0;
                    capture   = 1'b1;
                end
            end
            ACCESS: begin
                done = psel & penable & (wcnt == WS);
                if (!psel || done) begin
                    state_nxt = IDLE;
                end else if (wcnt != WS) begin
                    wcnt_nxt = wcnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Setup-phase capture; bus changes during access are ignored
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cap_idx   <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
            cap_strb  <= '0;
        end else if (capture) begin
            cap_idx   <= paddr[ADDR_W-1:OFF_W];
            cap_write <= pwrite;
            cap_wdata <= pwdata;
            cap_strb  <= pstrb;
        end
    end

    assign err      = {1'b0, cap_idx} >= DEPTH_EXT;
    assign mem_addr = cap_idx[MEM_AW-1:0];
    assign pready   = (state == ACCESS) & done;
    assign commit   = pready & cap_write & ~err;
    assign pslverr  = pready & err;
    assign prdata   = (pready & ~cap_write & ~err) ? mem[mem_addr] : '0;

    // Byte-lane write on the completing edge; storage has no reset
    always_ff @(posedge pclk) begin
        if (commit) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (cap_strb[i]) begin
                    mem[mem_addr][8*i +: 8] <= cap_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_ram_param.sv
// Directed bench for apb_ram_param: three instances covering zero wait,
// three wait states with a shortened depth, and two wait states for aborts.
module tb_apb_ram_param;

    logic        pclk;
    logic        presetn;
    logic [2:0]  psel_v;
    logic        penable;
    logic        pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    logic [31:0] prdata_a, prdata_b, prdata_c;
    logic        pready_a, pready_b, pready_c;
    logic        pslverr_a, pslverr_b, pslverr_c;

    int n_tests = 0;
    int n_fail  = 0;

    apb_ram_param #(.DATA_W(32), .ADDR_W(10), .DEPTH(256), .WAIT_STATES(0)) dut_a (
        .pclk(pclk), .presetn(presetn), .psel(psel_v[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
    );

    apb_ram_param #(.DATA_W(32), .ADDR_W(10), .DEPTH(200), .WAIT_STATES(3)) dut_b (
        .pclk(pclk), .presetn(presetn), .psel(psel_v[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
    );

    apb_ram_param #(.DATA_W(32), .ADDR_W(10), .DEPTH(256), .WAIT_STATES(2)) dut_c (
        .pclk(pclk), .presetn(presetn), .psel(psel_v[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_c), .pready(pready_c), .pslverr(pslverr_c)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic peek(input int unsigned sel, output logic rdy, output logic serr,
                        output logic [31:0] rdata);
        case (sel)
            0:       begin rdy = pready_a; serr = pslverr_a; rdata = prdata_a; end
            1:       begin rdy = pready_b; serr = pslverr_b; rdata = prdata_b; end
            default: begin rdy = pready_c; serr = pslverr_c; rdata = prdata_c; end
        endcase
    endtask

    // Entered and left just after a rising edge; returns data/err seen with pready
    task automatic xfer(input int unsigned sel, input logic wr, input logic [9:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rdata, output logic serr, output int cycles);
        logic        rdy;
        logic        e;
        logic [31:0] d;
        logic        got;
        psel_v  = 3'(1 << sel);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        got     = 1'b0;
        rdata   = '0;
        serr    = 1'b0;
        cycles  = 2;
        @(posedge pclk);
        #1 penable = 1'b1;
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge pclk);
            peek(sel, rdy, e, d);
            if (rdy) begin
                got   = 1'b1;
                rdata = d;
                serr  = e;
            end else begin
                @(posedge pclk);
                #1 cycles++;
            end
        end
        @(posedge pclk);
        #1;
        psel_v  = '0;
        penable = 1'b0;
        chk("xfer_completes", 64'(got), 64'd1);
    endtask

    logic [31:0] rd;
    logic        se;
    int          cyc;
    logic        r_rdy, r_err;
    logic [31:0] r_dat;

    initial begin
        presetn = 1'b0;
        psel_v  = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        repeat (3) @(posedge pclk);
        #1 presetn = 1'b1;

        // Idle outputs after reset
        @(negedge pclk);
        chk("rst_pready", 64'(pready_a), 64'd0);
        chk("rst_pslverr", 64'(pslverr_a), 64'd0);
        chk("rst_prdata", 64'(prdata_a), 64'd0);
        @(posedge pclk);
        #1;

        // Zero wait states: write then read back
        xfer(0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF, rd, se, cyc);
        chk("a_wr_cycles", 64'(cyc), 64'd2);
        chk("a_wr_err", 64'(se), 64'd0);
        chk("a_wr_prdata_zero", 64'(rd), 64'd0);
        xfer(0, 1'b0, 10'h010, 32'h0, 4'h0, rd, se, cyc);
        chk("a_rd_data", 64'(rd), 64'hDEADBEEF);
        chk("a_rd_cycles", 64'(cyc), 64'd2);
        chk("a_rd_err", 64'(se), 64'd0);

        // Byte strobes merge lanes 0 and 2
        xfer(0, 1'b1, 10'h020, 32'h11223344, 4'hF, rd, se, cyc);
        xfer(0, 1'b1, 10'h020, 32'hAABBCCDD, 4'b0101, rd, se, cyc);
        xfer(0, 1'b0, 10'h020, 32'h0, 4'h0, rd, se, cyc);
        chk("a_strb_merge", 64'(rd), 64'h11BB33DD);
        xfer(0, 1'b1, 10'h020, 32'hFFFFFFFF, 4'h0, rd, se, cyc);
        chk("a_strb0_err", 64'(se), 64'd0);
        xfer(0, 1'b0, 10'h022, 32'h0, 4'h0, rd, se, cyc);
        chk("a_strb0_keep_unaligned", 64'(rd), 64'h11BB33DD);

        // penable without setup phase is ignored
        psel_v  = 3'b001;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 10'h010;
        @(negedge pclk);
        chk("a_noset_pready0", 64'(pready_a), 64'd0);
        @(posedge pclk);
        #1;
        @(negedge pclk);
        chk("a_noset_pready1", 64'(pready_a), 64'd0);
        @(posedge pclk);
        #1 psel_v = '0;
        penable = 1'b0;

        // Three wait states, back-to-back transfers
        xfer(1, 1'b1, 10'h31C, 32'h0BADF00D, 4'hF, rd, se, cyc);
        chk("b_wr_cycles", 64'(cyc), 64'd5);
        xfer(1, 1'b0, 10'h31C, 32'h0, 4'h0, rd, se, cyc);
        chk("b_raw_data", 64'(rd), 64'h0BADF00D);
        chk("b_rd_cycles", 64'(cyc), 64'd5);

        // Out-of-range word index 200 on a 200-deep instance
        xfer(1, 1'b1, 10'h320, 32'h5A5A5A5A, 4'hF, rd, se, cyc);
        chk("b_oor_wr_err", 64'(se), 64'd1);
        xfer(1, 1'b0, 10'h320, 32'h0, 4'h0, rd, se, cyc);
        chk("b_oor_rd_err", 64'(se), 64'd1);
        chk("b_oor_rd_data", 64'(rd), 64'd0);
        xfer(1, 1'b0, 10'h31C, 32'h0, 4'h0, rd, se, cyc);
        chk("b_idx199_kept", 64'(rd), 64'h0BADF00D);
        chk("b_idx199_err", 64'(se), 64'd0);

        // Abort after one access cycle with two wait states
        xfer(2, 1'b1, 10'h040, 32'h12345678, 4'hF, rd, se, cyc);
        chk("c_wr_cycles", 64'(cyc), 64'd4);
        psel_v  = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 10'h040;
        pwdata  = 32'hFFFFFFFF;
        pstrb   = 4'hF;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(negedge pclk);
        chk("c_abort_pready_acc", 64'(pready_c), 64'd0);
        @(posedge pclk);
        #1 psel_v = '0;
        penable = 1'b0;
        @(negedge pclk);
        chk("c_abort_pready_drop", 64'(pready_c), 64'd0);
        @(posedge pclk);
        #1;
        xfer(2, 1'b0, 10'h040, 32'h0, 4'h0, rd, se, cyc);
        chk("c_abort_mem_kept", 64'(rd), 64'h12345678);
        chk("c_after_abort_cycles", 64'(cyc), 64'd4);

        // Reset in the completing access cycle drops the write
        psel_v  = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 10'h010;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(negedge pclk);
        peek(0, r_rdy, r_err, r_dat);
        chk("a_pre_rst_pready", 64'(r_rdy), 64'd1);
        chk("a_pre_rst_prdata", 64'(r_dat), 64'hDEADBEEF);
        @(posedge pclk);
        #1 psel_v = '0;
        penable = 1'b0;
        pwrite  = 1'b1;
        pwdata  = 32'hCAFEF00D;
        pstrb   = 4'hF;
        psel_v  = 3'b001;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        chk("mid_rst_pready", 64'(pready_a), 64'd0);
        chk("mid_rst_pslverr", 64'(pslverr_a), 64'd0);
        chk("mid_rst_prdata", 64'(prdata_a), 64'd0);
        @(posedge pclk);
        #1 psel_v = '0;
        penable = 1'b0;
        presetn = 1'b1;
        xfer(0, 1'b0, 10'h010, 32'h0, 4'h0, rd, se, cyc);
        chk("a_after_rst_data", 64'(rd), 64'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
